// File: rtl/param_stim_gen.sv
// param_stim_gen: width-parameterised sequential stimulus source.
//
// Steps an internal WIDTH-bit counter from 0 up to LAST_VAL (taken mod 2**WIDTH).
// Each value is offered on a valid/ready handshake. After every accepted transfer
// except the last, the bus is held idle for GAP_CYCLES cycles. One instance can
// drive a consumer of any width in place of hand-written initial-block stepping.
//
// Optional build macro PARAM_STIM_GRAY_EN: when defined, data carries the Gray
// code of the internal counter. Termination still uses the binary counter, so
// the state machine, timing and count are the same in both builds.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high reset
//   start  - begin a sequence; only sampled in IDLE or DONE
//   ready  - consumer accepts data this cycle
//   data   - current stimulus value (WIDTH bits)
//   valid  - data is offered
//   done   - sequence complete; sticky until the next start or reset
//   count  - transfers accepted in the current sequence; saturates at 255
module param_stim_gen #(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned LAST_VAL   = 3,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             done,
  output logic [7:0]       count
);

  localparam logic [WIDTH-1:0] LastEff = WIDTH'(LAST_VAL);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // Loading GAP_CYCLES-1 and counting down to 0 gives exactly GAP_CYCLES idle cycles.
  localparam logic [GapW-1:0] GapLoad = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StOffer, StGap, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [7:0]       count_q, count_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    count_d = count_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    done_d  = done_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StOffer;
          bin_d   = '0;
          count_d = '0;
          done_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
      StOffer: begin
        // valid is always high here, so ready alone marks a transfer.
        if (ready) begin
          count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          if (bin_q == LastEff) begin
            state_d = StDone;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (GAP_CYCLES == 0) begin
            bin_d = bin_q + 1'b1;
          end else begin
            state_d = StGap;
            valid_d = 1'b0;
            gap_d   = GapLoad;
          end
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StOffer;
          bin_d   = bin_q + 1'b1;
          valid_d = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      bin_q   <= '0;
      count_q <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef PARAM_STIM_GRAY_EN
  assign data = bin_q ^ (bin_q >> 1);
`else
  assign data = bin_q;
`endif

  assign valid = valid_q;
  assign done  = done_q;
  assign count = count_q;

endmodule

// File: tb/tb_param_stim_gen.sv
// Bench for param_stim_gen using three instances:
//   a: WIDTH=2 LAST_VAL=3 GAP_CYCLES=4  (gap timing, restart, mid-sequence reset)
//   b: WIDTH=3 LAST_VAL=7 GAP_CYCLES=0  (back-to-back with toggling ready)
//   c: WIDTH=2 LAST_VAL=5 GAP_CYCLES=1  (LAST_VAL wraps to 1)
// The stimulus thread queues the expected transfers. A per-instance monitor pops
// and compares on every handshake.
module tb_param_stim_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_a, start_a, ready_a, valid_a, done_a;
  logic [1:0] data_a;
  logic [7:0] count_a;
  logic       reset_b, start_b, ready_b, valid_b, done_b;
  logic [2:0] data_b;
  logic [7:0] count_b;
  logic       reset_c, start_c, ready_c, valid_c, done_c;
  logic [1:0] data_c;
  logic [7:0] count_c;

  param_stim_gen #(.WIDTH(2), .LAST_VAL(3), .GAP_CYCLES(4)) u_dut_a (
    .clock(clock), .reset(reset_a), .start(start_a), .ready(ready_a),
    .data(data_a), .valid(valid_a), .done(done_a), .count(count_a)
  );
  param_stim_gen #(.WIDTH(3), .LAST_VAL(7), .GAP_CYCLES(0)) u_dut_b (
    .clock(clock), .reset(reset_b), .start(start_b), .ready(ready_b),
    .data(data_b), .valid(valid_b), .done(done_b), .count(count_b)
  );
  param_stim_gen #(.WIDTH(2), .LAST_VAL(5), .GAP_CYCLES(1)) u_dut_c (
    .clock(clock), .reset(reset_c), .start(start_c), .ready(ready_c),
    .data(data_c), .valid(valid_c), .done(done_c), .count(count_c)
  );

  // Hand-written expected data per step.
`ifdef PARAM_STIM_GRAY_EN
  int exp2[4] = '{0, 1, 3, 2};
  int exp3[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
`else
  int exp2[4] = '{0, 1, 2, 3};
  int exp3[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

  typedef struct {
    int data;
    int count;
  } xfer_t;

  xfer_t q_a[$], q_b[$], q_c[$];
  xfer_t e_a, e_b, e_c;
  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitors: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clock) begin
    if (valid_a && ready_a) begin
      if (q_a.size() == 0) check("a unexpected xfer data", int'(data_a), -1);
      else begin
        e_a = q_a.pop_front();
        check("a xfer data", int'(data_a), e_a.data);
        check("a xfer count", int'(count_a), e_a.count);
      end
    end
  end

  always @(negedge clock) begin
    if (valid_b && ready_b) begin
      if (q_b.size() == 0) check("b unexpected xfer data", int'(data_b), -1);
      else begin
        e_b = q_b.pop_front();
        check("b xfer data", int'(data_b), e_b.data);
        check("b xfer count", int'(count_b), e_b.count);
      end
    end
  end

  always @(negedge clock) begin
    if (valid_c && ready_c) begin
      if (q_c.size() == 0) check("c unexpected xfer data", int'(data_c), -1);
      else begin
        e_c = q_c.pop_front();
        check("c xfer data", int'(data_c), e_c.data);
        check("c xfer count", int'(count_c), e_c.count);
      end
    end
  end

  initial begin
    bit held;
    int prev;
    reset_a = 1'b1; start_a = 1'b0; ready_a = 1'b0;
    reset_b = 1'b1; start_b = 1'b0; ready_b = 1'b0;
    reset_c = 1'b1; start_c = 1'b0; ready_c = 1'b0;
    tick();
    tick();
    check("a reset valid", int'(valid_a), 0);
    check("a reset data", int'(data_a), 0);
    check("a reset done", int'(done_a), 0);
    check("a reset count", int'(count_a), 0);
    // Reset and start together: reset wins.
    start_b = 1'b1;
    tick();
    check("b reset+start valid", int'(valid_b), 0);
    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0; start_b = 1'b0;
    tick();

    // 1: four transfers with 4 idle cycles between them.
    for (int i = 0; i < 4; i++) q_a.push_back(xfer_t'{exp2[i], i});
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("a valid pattern cyc%0d", i), int'(valid_a), (i % 5 == 0) ? 1 : 0);
      tick();
    end
    check("a t1 done", int'(done_a), 1);
    check("a t1 valid", int'(valid_a), 0);
    check("a t1 count", int'(count_a), 4);
    check("a t1 data", int'(data_a), exp2[3]);

    // 2: back-to-back, ready toggling; data must hold while not accepted.
    for (int i = 0; i < 8; i++) q_b.push_back(xfer_t'{exp3[i], i});
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 64 && !done_b; i++) begin
      ready_b = (i % 2 == 0);
      held = valid_b && !ready_b;
      prev = int'(data_b);
      tick();
      if (held) check("b hold data", int'(data_b), prev);
    end
    ready_b = 1'b0;
    check("b done", int'(done_b), 1);
    check("b count", int'(count_b), 8);
    check("b final data", int'(data_b), exp3[7]);
    check("b final valid", int'(valid_b), 0);

    // 3: LAST_VAL=5 wraps to 1 at WIDTH=2.
    q_c.push_back(xfer_t'{0, 0});
    q_c.push_back(xfer_t'{1, 1});
    ready_c = 1'b1;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int i = 0; i < 20 && !done_c; i++) tick();
    check("c done", int'(done_c), 1);
    check("c count", int'(count_c), 2);
    check("c final data", int'(data_c), 1);

    // 5: restart from DONE; start while offering is ignored.
    ready_a = 1'b0;
    q_a.push_back(xfer_t'{exp2[0], 0});
    q_a.push_back(xfer_t'{exp2[1], 1});
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a restart done", int'(done_a), 0);
    check("a restart valid", int'(valid_a), 1);
    check("a restart data", int'(data_a), 0);
    check("a restart count", int'(count_a), 0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a offer-start valid", int'(valid_a), 1);
    check("a offer-start data", int'(data_a), 0);
    check("a offer-start count", int'(count_a), 0);
    ready_a = 1'b1;
    tick();
    check("a gap valid", int'(valid_a), 0);
    check("a gap count", int'(count_a), 1);
    for (int i = 0; i < 4; i++) tick();
    check("a second offer valid", int'(valid_a), 1);
    check("a second offer data", int'(data_a), exp2[1]);
    tick();

    // 4: reset while in the gap after data=1 was accepted.
    check("a pre-reset count", int'(count_a), 2);
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    check("a midreset valid", int'(valid_a), 0);
    check("a midreset data", int'(data_a), 0);
    check("a midreset count", int'(count_a), 0);
    check("a midreset done", int'(done_a), 0);
    tick();
    check("a idle stays idle", int'(valid_a), 0);
    for (int i = 0; i < 4; i++) q_a.push_back(xfer_t'{exp2[i], i});
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 100 && !done_a; i++) tick();
    check("a replay done", int'(done_a), 1);
    check("a replay count", int'(count_a), 4);
    check("a replay data", int'(data_a), exp2[3]);

    tick();
    check("a leftover expected", q_a.size(), 0);
    check("b leftover expected", q_b.size(), 0);
    check("c leftover expected", q_c.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_stim_gen.md
Name: param_stim_gen

Overview:
- Parameterized-width sequential stimulus source: the driving end of a width-parameterized consumer (e.g. a `b ^ 0` style sink).
- Steps a WIDTH-bit value from 0 up to LAST_VAL.
- Presents each value on a valid/ready handshake, then holds it off-bus for a programmable gap.
- Replaces hand-written initial-block stepping in diags, so a single instance drives any consumer width.

Parameters:
- WIDTH, 2, bit width of data output; legal range 1..16.
- LAST_VAL, 3, final value emitted; effective value is LAST_VAL mod 2**WIDTH.
- GAP_CYCLES, 4, idle cycles inserted after each accepted transfer; 0 means back-to-back.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a sequence; sampled only in IDLE or DONE.
- ready  input  1  consumer accepts data this cycle.
- data   output WIDTH  current stimulus value.
- valid  output 1  data is offered.
- done   output 1  sequence complete; sticky until next start or reset.
- count  output 8  number of transfers accepted in current sequence; saturates at 255.

Behaviour:
- Reset:
  - Sampled on clock rise.
  - Forces state IDLE, data=0, valid=0, done=0, count=0, gap counter=0.
  - Reset mid-sequence aborts with no further transfers; the consumer sees valid drop the cycle after reset is sampled.
- States: IDLE, OFFER, GAP, DONE.
- IDLE:
  - valid=0.
  - start=1 -> OFFER next cycle with data=0, valid=1, count=0, done=0.
- OFFER:
  - valid=1; data stable while valid && !ready.
  - On valid && ready:
    - count increments; saturates at 255.
    - If data == effective LAST_VAL -> DONE: valid=0, done=1.
    - Else if GAP_CYCLES == 0 -> stay in OFFER, data+1 next cycle, valid stays 1.
    - Else -> GAP: valid=0, gap counter loaded with GAP_CYCLES-1.
- GAP:
  - valid=0.
  - Counter decrements each cycle.
  - When counter == 0 -> OFFER with data+1, valid=1.
  - Result: exactly GAP_CYCLES cycles with valid=0 between transfers.
- DONE:
  - valid=0, done=1, data holds last value.
  - start=1 -> OFFER with data=0, done=0, count=0 (restart).
- Latency: start sampled at edge N -> valid=1 after edge N; first transfer at the earliest edge where ready=1.
- Arithmetic:
  - data increment is modulo 2**WIDTH.
  - With effective LAST_VAL == 0, the sequence is a single transfer of 0.
- start outside IDLE/DONE is ignored.
- reset and start in the same cycle: reset wins, state IDLE.
- ready while valid=0 is ignored.

Optional Feature:
- Macro: PARAM_STIM_GRAY_EN.
- Defined:
  - data presents the Gray code of the internal binary counter (bin ^ (bin >> 1)).
  - Termination compares the binary counter against LAST_VAL.
  - Consecutive transfers therefore differ in exactly one bit.
- Undefined: data is the plain binary counter.
- State machine, timing and count are identical either way.

Test Plan:
1. WIDTH=2, LAST_VAL=3, GAP_CYCLES=4, ready=1 constant, start pulse:
   - data 0,1,2,3 accepted.
   - 4 valid-low cycles between each.
   - done=1 one cycle after 3 accepted; count=4.
2. WIDTH=3, LAST_VAL=7, GAP_CYCLES=0, ready toggling 1/0 each cycle:
   - data held while ready=0.
   - 8 transfers 0..7 in order; count=8; done=1.
3. WIDTH=2, LAST_VAL=5 (effective 1):
   - transfers 0,1 only; done=1; count=2.
4. Reset asserted in GAP after data=1 accepted (WIDTH=2, LAST_VAL=3):
   - next cycle valid=0, data=0, count=0, done=0, IDLE.
   - New start replays from 0.
5. In DONE, start pulse:
   - done clears next cycle; data=0, valid=1; count restarts at 0.
   - start during OFFER has no effect.
6. PARAM_STIM_GRAY_EN defined, WIDTH=3, LAST_VAL=7, GAP_CYCLES=0, ready=1:
   - data sequence 0,1,3,2,6,7,5,4; count=8; done=1.
